bnn_run_scheduler: RTL
======================

// Module: bnn_run_scheduler
// PURPOSE
//  Sequences one BNN inference per request. Sits between controller_fsm (requester) and
//  bnn_interface/image_buffer (resource). Waits for a full image buffer, holds bnn_enable
//  until result_ready, latches the digit, holds it until acknowledged, then pulses clear.
//  A watchdog aborts stalled runs and reports a sticky timeout error.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max cycles allowed in ARM or RUN before error (>=4)
//  CLEAR_CYCLES    2     width of bnn_clear pulse in cycles (>=1)
//  RUN_CNT_W       8     width of successful-run counter
// PORTS
//  clk           in   1          system clock
//  rst_n         in   1          asynchronous active-low reset
//  start_req     in   1          request a run; sampled only in IDLE
//  abort         in   1          cancel the current run
//  buffer_full   in   1          image buffer holds a complete frame
//  result_ready  in   1          BNN result valid this cycle
//  result_in     in   4          BNN digit
//  result_ack    in   1          consumer has taken result_out
//  bnn_enable    out  1          run enable to bnn_interface
//  bnn_clear     out  1          clear to image buffer and BNN
//  busy          out  1          high in every state except IDLE
//  result_out    out  4          latched digit
//  result_valid  out  1          result_out valid; high only in HOLD
//  timeout_err   out  1          sticky watchdog error
//  state_o       out  3          current state code (sched_state_t)
//  run_count     out  RUN_CNT_W  completed runs, wraps modulo 2^RUN_CNT_W
//  last_latency  out  16         RUN-entry-to-result cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered. Reset values: every output 0; state = IDLE.
//  - IDLE: if start_req, go to ARM at the next edge, set busy, and clear timeout_err.
//  - ARM: if buffer_full, go to RUN. bnn_enable is 1 in the first RUN cycle.
//    With buffer_full already high, start_req at edge N gives bnn_enable=1 after edge N+2.
//  - RUN: bnn_enable=1. On result_ready: latch result_in, set result_valid,
//    drop bnn_enable, go to HOLD. This takes one edge.
//  - HOLD: result_valid=1 until result_ack is sampled. Then clear result_valid,
//    increment run_count, and go to CLEAR.
//  - CLEAR: bnn_clear=1 for exactly CLEAR_CYCLES cycles, then go to IDLE.
//  - ERROR: one cycle, entered on watchdog expiry. Sets timeout_err and drops bnn_enable.
//    Then goes to CLEAR. run_count is unchanged.
//  - Watchdog: zeroed on every state entry. Counts cycles in ARM and RUN.
//    It expires when the count equals TIMEOUT_CYCLES-1.
//  - Priority within a cycle: abort > result_ready > watchdog expiry.
//    If result_ready and expiry occur together, the result wins and there is no error.
//  - abort in ARM, RUN or HOLD: go to CLEAR; result_valid=0, bnn_enable=0, run_count unchanged.
//    abort in IDLE, CLEAR or ERROR is ignored.
//  - start_req outside IDLE is ignored (not queued). result_ack outside HOLD is ignored.
//  - result_ready outside RUN is ignored; result_out keeps its last value.
//  - Asynchronous reset mid-run immediately returns every output to its reset value.
// CONFIGURATION
//  BNN_SCHED_PERF_CNT_EN defined:
//    - A 16-bit counter starts at 0 on RUN entry and increments each RUN cycle.
//    - The counter saturates at 16'hFFFF.
//    - On result_ready it is copied into last_latency, which holds until the next result.
//  BNN_SCHED_PERF_CNT_EN undefined:
//    - No counter is built. last_latency is tied to 16'h0.
// STRUCTURE
//  - Package bnn_sched_pkg:
//    - sched_state_t enum: IDLE=0, ARM=1, RUN=2, HOLD=3, CLEAR=4, ERROR=5.
//    - Default constants for TIMEOUT_CYCLES and CLEAR_CYCLES.
//    - LATENCY_W=16.
//  - One sub-module: sched_watchdog.
//    - Parameter LIMIT; inputs restart and count_en; output expired.
//    - Counter width $clog2(LIMIT).
//  - The FSM, result latch and run counter live in the top module.
// TESTING
//  1. buffer_full=1, start_req pulse at cycle 0, result_ready with result_in=4'd7 at cycle 5:
//     bnn_enable=1 for cycles 3..5; result_out=7 and result_valid=1 from cycle 6;
//     result_ack at 8 -> bnn_clear=1 for cycles 9..10, run_count=1, IDLE at 11.
//  2. TIMEOUT_CYCLES=16, buffer_full=0, start_req ->
//     timeout_err=1 exactly 16 cycles after ARM entry; ERROR->CLEAR->IDLE; run_count=0.
//  3. result_ready in the same cycle as watchdog expiry in RUN ->
//     HOLD with the result latched; timeout_err=0.
//  4. abort during HOLD with result_out=3 ->
//     result_valid=0 next cycle, bnn_clear pulse, run_count unchanged.
//     A second start_req during CLEAR is ignored.
//  5. rst_n low while in RUN, then released ->
//     all outputs 0, state_o=IDLE; start_req then completes a normal run.
//  6. With BNN_SCHED_PERF_CNT_EN, result_ready 10 cycles after RUN entry -> last_latency=10.
//     Without the macro -> last_latency=0.

Source files
------------

// File: rtl/bnn_sched_pkg.sv
// Shared types and defaults for the BNN run scheduler.
// State codes are visible on state_o, so their values are fixed.
package bnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4,
    ERROR = 3'd5
  } sched_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 4096;
  localparam int unsigned CLEAR_CYCLES_DEF   = 2;
  localparam int unsigned LATENCY_W          = 16;

  function automatic logic [LATENCY_W-1:0] sat_inc(input logic [LATENCY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bnn_run_scheduler_watchdog.sv
// Stall watchdog: counts enabled cycles since the last restart and flags
// expiry once the count reaches LIMIT-1.
module sched_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count_en && (cnt_q == LAST);

endmodule

// File: rtl/bnn_run_scheduler.sv
// Sequences one BNN inference per request with watchdog and result handshake.
// Optional latency counter enabled by defining BNN_SCHED_PERF_CNT_EN.
module bnn_run_scheduler
  import bnn_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CLEAR_CYCLES   = CLEAR_CYCLES_DEF,
  parameter int unsigned RUN_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_req,
  input  logic                 abort,
  input  logic                 buffer_full,
  input  logic                 result_ready,
  input  logic [3:0]           result_in,
  input  logic                 result_ack,
  output logic                 bnn_enable,
  output logic                 bnn_clear,
  output logic                 busy,
  output logic [3:0]           result_out,
  output logic                 result_valid,
  output logic                 timeout_err,
  output logic [2:0]           state_o,
  output logic [RUN_CNT_W-1:0] run_count,
  output logic [LATENCY_W-1:0] last_latency
);

  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);

  sched_state_t         state_q, state_d;
  logic                 arm_first_q, arm_first_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic                 busy_q, en_q, clr_q, rv_q;
  logic                 terr_q, terr_d;
  logic [3:0]           res_q, res_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 take_result, count_run;
  logic                 wd_restart, wd_count_en, wd_expired;

  assign wd_restart  = (state_d != state_q);
  assign wd_count_en = (state_q == ARM) || (state_q == RUN);

  sched_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (wd_restart),
    .count_en(wd_count_en),
    .expired (wd_expired)
  );

  // The first ARM cycle ignores buffer_full so a stale full flag from the
  // previous frame is never trusted; a fresh run therefore arms for 2 cycles.
  always_comb begin
    state_d     = state_q;
    take_result = 1'b0;
    count_run   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) state_d = ARM;
      end
      ARM: begin
        if (abort)                             state_d = CLEAR;
        else if (buffer_full && !arm_first_q)  state_d = RUN;
        else if (wd_expired)                   state_d = ERROR;
      end
      RUN: begin
        if (abort) begin
          state_d = CLEAR;
        end else if (result_ready) begin
          state_d     = HOLD;
          take_result = 1'b1;
        end else if (wd_expired) begin
          state_d = ERROR;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = CLEAR;
        end else if (result_ack) begin
          state_d   = CLEAR;
          count_run = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) state_d = IDLE;
      end
      ERROR: begin
        state_d = CLEAR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    arm_first_d = (state_d == ARM) && (state_q != ARM);
    clr_cnt_d   = ((state_q == CLEAR) && (state_d == CLEAR)) ? clr_cnt_q + 1'b1 : '0;

    terr_d = terr_q;
    if ((state_d == ERROR) && (state_q != ERROR)) begin
      terr_d = 1'b1;
    end else if ((state_q == IDLE) && (state_d == ARM)) begin
      terr_d = 1'b0;
    end

    res_d     = take_result ? result_in : res_q;
    run_cnt_d = count_run ? run_cnt_q + 1'b1 : run_cnt_q;
  end

  // Output flags are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      arm_first_q <= 1'b0;
      clr_cnt_q   <= '0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      rv_q        <= 1'b0;
      terr_q      <= 1'b0;
      res_q       <= '0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      arm_first_q <= arm_first_d;
      clr_cnt_q   <= clr_cnt_d;
      busy_q      <= (state_d != IDLE);
      en_q        <= (state_d == RUN);
      clr_q       <= (state_d == CLEAR);
      rv_q        <= (state_d == HOLD);
      terr_q      <= terr_d;
      res_q       <= res_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

`ifdef BNN_SCHED_PERF_CNT_EN
  logic [LATENCY_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [LATENCY_W-1:0] last_lat_q, last_lat_d;

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if ((state_d == RUN) && (state_q != RUN)) begin
      lat_cnt_d = '0;
    end else if (state_q == RUN) begin
      lat_cnt_d = sat_inc(lat_cnt_q);
    end
    last_lat_d = take_result ? lat_cnt_q : last_lat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign last_latency = last_lat_q;
`else
  assign last_latency = '0;
`endif

  assign bnn_enable   = en_q;
  assign bnn_clear    = clr_q;
  assign busy         = busy_q;
  assign result_out   = res_q;
  assign result_valid = rv_q;
  assign timeout_err  = terr_q;
  assign state_o      = state_q;
  assign run_count    = run_cnt_q;

endmodule
